gaussian_window_ctrl: RTL and testbench

Streaming 3x3 window sequencer for the 3x3 Gaussian filter datapath in the camera-to-VGA path. It accepts a raster stream of RGB444 pixels, holds two line buffers and a 3x3 register window, and presents the nine window taps to the filter. It registers the filter result back out with frame/line framing, border blanking and a runtime bypass. The filter itself stays combinational and is instantiated beside this block.

---
 rtl/gaussian_window_ctrl.sv | 189 ++++++++++++++++++
 tb/tb_gaussian_window_ctrl.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/gaussian_window_ctrl.sv
// 3x3 window sequencer for the Gaussian filter: two line buffers, a register window,
// raster position tracking and a registered, border-blanked output stage.
module gaussian_window_ctrl #(
   parameter int IMG_WIDTH  = 320,
   parameter int IMG_HEIGHT = 240
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic        in_sof,
   input  logic [11:0] in_data,
   input  logic        bypass,
   output logic [11:0] win_00,
   output logic [11:0] win_01,
   output logic [11:0] win_02,
   output logic [11:0] win_10,
   output logic [11:0] win_11,
   output logic [11:0] win_12,
   output logic [11:0] win_20,
   output logic [11:0] win_21,
   output logic [11:0] win_22,
   input  logic [11:0] filt_result,
   output logic        out_valid,
   output logic        out_sof,
   output logic        out_eol,
   output logic [11:0] out_data,
   output logic        frame_done,
   output logic        frame_err
);
   // state  | meaning
   // S_IDLE | waiting for in_sof; pixels without it are dropped
   // S_RUN  | inside a frame, x/y hold the position of the next pixel
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   localparam int XW = $clog2(IMG_WIDTH);
   localparam int YW = $clog2(IMG_HEIGHT);

   logic [0:0]    state;
   logic [XW-1:0] x;
   logic [YW-1:0] y;

   logic          accept;
   logic          restart;
   logic          sof_err;
   logic [XW-1:0] px;
   logic [YW-1:0] py;
   logic          at_eol;
   logic          at_last;

   logic [11:0]   lb0 [IMG_WIDTH];
   logic [11:0]   lb1 [IMG_WIDTH];
   logic [11:0]   lb0_q;
   logic [11:0]   lb1_q;

   logic          s1_valid, s1_border, s1_sof, s1_eol, s1_last, s1_bypass;
   logic [11:0]   s1_pix;
   logic          s2_valid, s2_border, s2_sof, s2_eol, s2_last, s2_bypass;

   always_comb begin
      accept  = in_valid && (state == S_RUN || in_sof);
      restart = in_valid && in_sof;
      sof_err = restart && (state == S_RUN) && (x != '0 || y != '0);
      px      = restart ? '0 : x;
      py      = restart ? '0 : y;
      at_eol  = (px == XW'(IMG_WIDTH - 1));
      at_last = at_eol && (py == YW'(IMG_HEIGHT - 1));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= S_IDLE;
         x         <= '0;
         y         <= '0;
         frame_err <= 1'b0;
      end else begin
         if (sof_err)
            frame_err <= 1'b1;
         if (accept) begin
            if (at_last) begin
               state <= S_IDLE;
               x     <= '0;
               y     <= '0;
            end else if (at_eol) begin
               state <= S_RUN;
               x     <= '0;
               y     <= py + YW'(1);
            end else begin
               state <= S_RUN;
               x     <= px + XW'(1);
               y     <= py;
            end
         end
      end
   end

   // Registered reads see the pre-write contents, so LB1 takes the old LB0 line.
   always_ff @(posedge clk) begin
      if (accept) begin
         lb0_q    <= lb0[px];
         lb1_q    <= lb1[px];
         lb1[px]  <= lb0[px];
         lb0[px]  <= in_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid  <= 1'b0;
         s1_border <= 1'b0;
         s1_sof    <= 1'b0;
         s1_eol    <= 1'b0;
         s1_last   <= 1'b0;
         s1_bypass <= 1'b0;
         s1_pix    <= 12'h000;
      end else begin
         s1_valid <= accept;
         if (accept) begin
            s1_border <= (px < XW'(2)) || (py < YW'(2));
            s1_sof    <= (px == '0) && (py == '0);
            s1_eol    <= at_eol;
            s1_last   <= at_last;
            s1_bypass <= bypass;
            s1_pix    <= in_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_00    <= 12'h000;
         win_01    <= 12'h000;
         win_02    <= 12'h000;
         win_10    <= 12'h000;
         win_11    <= 12'h000;
         win_12    <= 12'h000;
         win_20    <= 12'h000;
         win_21    <= 12'h000;
         win_22    <= 12'h000;
         s2_valid  <= 1'b0;
         s2_border <= 1'b0;
         s2_sof    <= 1'b0;
         s2_eol    <= 1'b0;
         s2_last   <= 1'b0;
         s2_bypass <= 1'b0;
      end else begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            win_00    <= win_01;
            win_01    <= win_02;
            win_02    <= lb1_q;
            win_10    <= win_11;
            win_11    <= win_12;
            win_12    <= lb0_q;
            win_20    <= win_21;
            win_21    <= win_22;
            win_22    <= s1_pix;
            s2_border <= s1_border;
            s2_sof    <= s1_sof;
            s2_eol    <= s1_eol;
            s2_last   <= s1_last;
            s2_bypass <= s1_bypass;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid  <= 1'b0;
         out_sof    <= 1'b0;
         out_eol    <= 1'b0;
         frame_done <= 1'b0;
         out_data   <= 12'h000;
      end else begin
         out_valid  <= s2_valid;
         out_sof    <= s2_valid && s2_sof;
         out_eol    <= s2_valid && s2_eol;
         frame_done <= s2_valid && s2_last;
         if (s2_valid) begin
            if (s2_border)
               out_data <= 12'h000;
            else if (s2_bypass)
               out_data <= win_11;
            else
               out_data <= filt_result;
         end
      end
   end
endmodule

// File: tb/tb_gaussian_window_ctrl.sv
// Scoreboard bench for gaussian_window_ctrl on a 4x3 frame with a win_00^win_22 filter stub.
module tb_gaussian_window_ctrl;
   localparam int W = 4;
   localparam int H = 3;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_sof;
   logic [11:0] in_data;
   logic        bypass;
   logic [11:0] win_00, win_01, win_02, win_10, win_11, win_12, win_20, win_21, win_22;
   logic [11:0] filt_result;
   logic        out_valid, out_sof, out_eol, frame_done, frame_err;
   logic [11:0] out_data;

   gaussian_window_ctrl #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_sof(in_sof), .in_data(in_data),
      .bypass(bypass),
      .win_00(win_00), .win_01(win_01), .win_02(win_02),
      .win_10(win_10), .win_11(win_11), .win_12(win_12),
      .win_20(win_20), .win_21(win_21), .win_22(win_22),
      .filt_result(filt_result), .out_valid(out_valid), .out_sof(out_sof), .out_eol(out_eol),
      .out_data(out_data), .frame_done(frame_done), .frame_err(frame_err)
   );

   assign filt_result = win_00 ^ win_22;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [11:0] d;
      logic        sof;
      logic        eol;
      logic        done;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   int   n_out = 0;
   int   n_done = 0;
   int   tap_cyc = -1;

   // Hand-computed outputs for pixels 0x001..0x00C in raster order.
   logic [11:0] exp_byp  [12] = '{12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0,
                                  12'h0, 12'h0, 12'h0, 12'h0, 12'h006, 12'h007};
   logic [11:0] exp_filt [12] = '{12'h0, 12'h0, 12'h0, 12'h0, 12'h0, 12'h0,
                                  12'h0, 12'h0, 12'h0, 12'h0, 12'h00A, 12'h00E};
   logic [11:0] exp_taps [9]  = '{12'h001, 12'h002, 12'h003, 12'h005, 12'h006,
                                  12'h007, 12'h009, 12'h00A, 12'h00B};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         if (!out_valid)
            chk("flags_without_valid", int'({out_sof, out_eol, frame_done}), 0);
         if (out_valid) begin
            n_out++;
            if (frame_done) n_done++;
            if (sb.size() == 0) begin
               chk("unexpected_out_valid", 1, 0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("out_data", int'(out_data), int'(e.d));
               chk("out_sof", int'(out_sof), int'(e.sof));
               chk("out_eol", int'(out_eol), int'(e.eol));
               chk("frame_done", int'(frame_done), int'(e.done));
               chk("latency", cyc - e.acc, 2);
            end
         end
         if (cyc == tap_cyc) begin
            logic [11:0] taps [9];
            taps = '{win_00, win_01, win_02, win_10, win_11, win_12, win_20, win_21, win_22};
            for (int k = 0; k < 9; k++)
               chk($sformatf("win_tap_%0d", k), int'(taps[k]), int'(exp_taps[k]));
         end
      end
   end

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         in_valid = 1'b0;
         in_sof   = 1'b0;
      end
   endtask

   // Drive one pixel at a negedge; it is accepted at the following posedge.
   task automatic send(input logic [11:0] d, input logic sof, input logic byp,
                       input bit expect_out, input logic [11:0] ed,
                       input logic esof, input logic eeol, input logic edone);
      exp_t e;
      @(negedge clk);
      in_valid = 1'b1;
      in_sof   = sof;
      in_data  = d;
      bypass   = byp;
      if (expect_out) begin
         e.d = ed; e.sof = esof; e.eol = eeol; e.done = edone; e.acc = cyc + 1;
         sb.push_back(e);
      end
   endtask

   task automatic run_frame(input logic byp, input int gap_pct, input bit tap_check, input int npix);
      for (int i = 0; i < npix; i++) begin
         for (int g = 0; g < 3 && $urandom_range(99) < gap_pct; g++)
            idle(1);
         send(12'(i + 1), i == 0, byp, 1'b1, byp ? exp_byp[i] : exp_filt[i],
              i == 0, (i % W) == W - 1, i == W * H - 1);
         if (tap_check && i == 10)
            tap_cyc = cyc + 2;
      end
      idle(1);
   endtask

   task automatic drain(input string name);
      int k;
      k = 0;
      while (sb.size() != 0 && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk({name, "_drained"}, sb.size(), 0);
   endtask

   initial begin
      int base_out, base_done;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      in_data  = 12'h000;
      bypass   = 1'b0;
      #1;
      chk("rst_out_valid", int'(out_valid), 0);
      chk("rst_flags", int'({out_sof, out_eol, frame_done, frame_err}), 0);
      chk("rst_out_data", int'(out_data), 0);
      chk("rst_taps", int'(win_00 | win_11 | win_22 | win_02 | win_20), 0);
      idle(3);
      rst_n = 1'b1;

      // Pixels without in_sof while idle are dropped.
      base_out = n_out;
      for (int i = 0; i < 5; i++) send(12'hABC, 1'b0, 1'b1, 1'b0, 12'h0, 1'b0, 1'b0, 1'b0);
      idle(6);
      chk("idle_no_output", n_out - base_out, 0);

      base_done = n_done;
      run_frame(1'b1, 0, 1'b0, W * H);
      drain("bypass_frame");
      chk("bypass_frame_done_count", n_done - base_done, 1);
      chk("frame_err_clean", int'(frame_err), 0);

      base_done = n_done;
      run_frame(1'b0, 0, 1'b1, W * H);
      drain("filter_frame");
      chk("filter_frame_done_count", n_done - base_done, 1);

      base_out = n_out; base_done = n_done;
      run_frame(1'b1, 50, 1'b0, W * H);
      drain("gap_bypass");
      chk("gap_bypass_out_count", n_out - base_out, W * H);
      chk("gap_bypass_done_count", n_done - base_done, 1);

      base_out = n_out; base_done = n_done;
      run_frame(1'b0, 50, 1'b0, W * H);
      drain("gap_filter");
      chk("gap_filter_out_count", n_out - base_out, W * H);
      chk("gap_filter_done_count", n_done - base_done, 1);

      // in_sof arriving at (1,1) restarts the frame and latches frame_err.
      base_done = n_done;
      for (int i = 0; i < 5; i++)
         send(12'(i + 1), i == 0, 1'b1, 1'b1, 12'h000, i == 0, i == 3, 1'b0);
      chk("frame_err_before_restart", int'(frame_err), 0);
      run_frame(1'b1, 0, 1'b0, W * H);
      drain("restart_frame");
      chk("restart_done_count", n_done - base_done, 1);
      chk("frame_err_set", int'(frame_err), 1);
      run_frame(1'b1, 0, 1'b0, W * H);
      drain("after_err_frame");
      chk("frame_err_sticky", int'(frame_err), 1);

      // Reset in mid-frame clears outputs asynchronously.
      run_frame(1'b1, 0, 1'b0, 7);
      @(negedge clk);
      #2 rst_n = 1'b0;
      in_valid = 1'b0;
      in_sof   = 1'b0;
      #1;
      chk("midrst_out_valid", int'(out_valid), 0);
      chk("midrst_flags", int'({out_sof, out_eol, frame_done, frame_err}), 0);
      chk("midrst_out_data", int'(out_data), 0);
      chk("midrst_taps", int'(win_11 | win_12 | win_21 | win_22), 0);
      sb.delete();
      idle(2);
      rst_n = 1'b1;
      base_done = n_done;
      run_frame(1'b1, 0, 1'b0, W * H);
      drain("post_reset_frame");
      chk("post_reset_done_count", n_done - base_done, 1);
      chk("post_reset_frame_err", int'(frame_err), 0);

      idle(2);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule
